// File: rtl/kt8_pkg.sv
// Shared encodings for the kt8 datapath: command types, sequencer states and the
// ALU opcode width.
package kt8_pkg;

  localparam int OP_W = 4;

  typedef enum logic [1:0] {
    CMD_ALU  = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_MOVE = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/kt8_regfile.sv
// kt8 register file: NREG x DW storage, two combinational read ports and one write
// port. Register 0 is hardwired to zero.
module kt8_regfile #(
  parameter  int DW   = 8,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem[raddr_b_i];

endmodule

// File: rtl/kt8_datareg.sv
// kt8 register file plus IDLE/EXEC/DONE execute sequencer feeding the ALU.
// Define KT8_DATAREG_ZFLAG_EN to add the zero flag register and zero_o port.
module kt8_datareg
  import kt8_pkg::*;
#(
  parameter  int DW   = 8,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_type_i,
  input  logic [OP_W-1:0] cmd_op_i,
  input  logic [AW-1:0]   cmd_rd_i,
  input  logic [AW-1:0]   cmd_rsa_i,
  input  logic [AW-1:0]   cmd_rsb_i,
  input  logic [DW-1:0]   cmd_imm_i,
  output logic [DW-1:0]   a_o,
  output logic [DW-1:0]   b_o,
  output logic [OP_W-1:0] op_o,
  input  logic [DW-1:0]   r_i,
  output logic            done_o,
  output logic [DW-1:0]   result_o
`ifdef KT8_DATAREG_ZFLAG_EN
  ,
  output logic            zero_o
`endif
);

  state_e          state;
  cmd_type_e       type_p0;
  logic [OP_W-1:0] op_p0;
  logic [AW-1:0]   rd_p0, rsa_p0, rsb_p0;
  logic [DW-1:0]   imm_p0;
  logic [DW-1:0]   rd_a, rd_b, wr_data;
  logic            wr_en, alu_exec;

  kt8_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (wr_en),
    .waddr_i   (rd_p0),
    .wdata_i   (wr_data),
    .raddr_a_i (rsa_p0),
    .rdata_a_o (rd_a),
    .raddr_b_i (rsb_p0),
    .rdata_b_o (rd_b)
  );

  assign cmd_ready_o = (state == S_IDLE);
  assign alu_exec    = (state == S_EXEC) && (type_p0 == CMD_ALU);

  // Stage p0: command fields captured at the handshake edge
  always_ff @(posedge clk_i) begin
    if (cmd_ready_o && cmd_valid_i) begin
      type_p0 <= cmd_type_e'(cmd_type_i);
      op_p0   <= cmd_op_i;
      rd_p0   <= cmd_rd_i;
      rsa_p0  <= cmd_rsa_i;
      rsb_p0  <= cmd_rsb_i;
      imm_p0  <= cmd_imm_i;
    end
  end

  // ALU inputs held at zero unless an ALU command is executing
  assign a_o  = alu_exec ? rd_a  : '0;
  assign b_o  = alu_exec ? rd_b  : '0;
  assign op_o = alu_exec ? op_p0 : '0;

  always_comb begin
    wr_data = '0;
    case (type_p0)
      CMD_ALU:  wr_data = r_i;
      CMD_LOAD: wr_data = imm_p0;
      CMD_MOVE: wr_data = rd_a;
      default:  wr_data = '0;
    endcase
  end

  assign wr_en = (state == S_EXEC) && (type_p0 != CMD_RSVD);

  // Stage p1: sequencer and retire outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) state <= S_EXEC;
        end
        S_EXEC: begin
          done_o   <= 1'b1;
          result_o <= wr_data;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_o   <= 1'b0;
          result_o <= '0;
          state    <= S_IDLE;
        end
        default: begin
          done_o   <= 1'b0;
          result_o <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef KT8_DATAREG_ZFLAG_EN
  logic zflag;

  // Flag tracks every ALU result, including ones discarded by a write to r0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) zflag <= 1'b0;
    else if (alu_exec) zflag <= (r_i == '0);
  end

  assign zero_o = zflag;
`endif

endmodule

// File: doc/kt8_datareg.md
# kt8_datareg

Data register file and execute sequencer for the kt8 8-bit datapath, sitting directly upstream of the combinational ALU. It accepts one command at a time over a valid/ready handshake and supports three commands: ALU operation, immediate load, and register move. For ALU commands it presents two register operands and an opcode to the ALU, captures the ALU result and writes it back to a destination register. Completion is reported with a one-cycle done pulse.

## Interface
Parameters:
- DW, 8, data width; must match the ALU operand width.
- NREG, 8, number of registers; power of two, at least 2.
- AW, $clog2(NREG), register address width; derived, never overridden.

Ports:
- clk_i, in, 1: clock. One clock domain, rising edge.
- rst_ni, in, 1: reset. Asynchronous, active-low.
- cmd_valid_i, in, 1: command present.
- cmd_ready_o, out, 1: sequencer can accept a command.
- cmd_type_i, in, 2: command type. 0 = ALU, 1 = LOAD immediate, 2 = MOVE, 3 = reserved (treated as a no-op).
- cmd_op_i, in, 4: ALU opcode, forwarded to the ALU.
- cmd_rd_i, in, AW: destination register.
- cmd_rsa_i, in, AW: source A register.
- cmd_rsb_i, in, AW: source B register.
- cmd_imm_i, in, DW: immediate for LOAD.
- a_o, out, DW: ALU operand A.
- b_o, out, DW: ALU operand B.
- op_o, out, 4: ALU opcode.
- r_i, in, DW: ALU result (combinational from a_o, b_o, op_o).
- done_o, out, 1: one-cycle pulse when a command retires.
- result_o, out, DW: value written by the retiring command.
- zero_o, out, 1: zero flag. Present only with the configuration macro defined.

## Operation
- The FSM has three states: IDLE, EXEC and DONE. Reset state is IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i && cmd_ready_o, latch all command fields and go to EXEC.
  - With no handshake, stay in IDLE.
- EXEC (exactly one cycle):
  - For ALU commands: a_o = reg[rsa], b_o = reg[rsb], op_o = latched op.
  - At the closing edge, write the selected data to reg[rd]:
    - ALU: r_i.
    - LOAD: imm.
    - MOVE: reg[rsa].
    - Reserved: no write.
  - Go to DONE.
- DONE (exactly one cycle):
  - done_o = 1.
  - result_o = the written value; 0 for reserved commands.
  - Go to IDLE.
- Register 0 always reads 0. Writes to register 0 are discarded, but done_o still pulses and result_o shows the discarded value.
- a_o, b_o and op_o are 0 in every state other than EXEC with an ALU command. This keeps the ALU inputs quiet.
- Operands are read during EXEC, so rd == rsa or rd == rsb reads the old value and writes the new value at the edge.
- Arithmetic is done in the ALU. This block performs no width extension; all data paths are DW bits.
- cmd_ready_o is 0 in EXEC and DONE. Command inputs are ignored there, and cmd_valid_i may stay asserted without effect until IDLE.

## Timing
- A handshake at edge N produces:
  - EXEC during cycle N..N+1.
  - The register write at edge N+1.
  - done_o high during cycle N+1..N+2.
  - cmd_ready_o high again after edge N+2.
- Throughput is one command per 3 cycles. Back-to-back valid is accepted on every third edge.
- Reset values: all registers 0, state IDLE, cmd_ready_o 1, done_o 0, result_o 0, a_o/b_o/op_o 0, zero_o 0.
- Reset asserted mid-command (EXEC or DONE) aborts the command. The write does not occur if reset arrives before the EXEC closing edge, and no done pulse is produced.
- r_i is sampled only at the EXEC closing edge; its value at other times is don't-care.

## Configuration
- KT8_DATAREG_ZFLAG_EN defined:
  - zero_o port exists.
  - A flag register updates at every ALU-command write, including writes to register 0, with (r_i == 0).
  - LOAD, MOVE and reserved commands leave the flag unchanged.
  - Reset value is 0.
- Undefined: no zero_o port and no flag register.

## Structure
- Shared package kt8_pkg holds:
  - The cmd_type encodings: CMD_ALU, CMD_LOAD, CMD_MOVE, CMD_RSVD.
  - The FSM state type: S_IDLE, S_EXEC, S_DONE.
  - The OP_W = 4 constant shared with the ALU.
- One sub-module, kt8_regfile, is the natural split:
  - NREG x DW storage, two combinational read ports and one write port.
  - Register 0 hardwired to 0.
  - Asynchronous active-low clear.
- The sequencer, flag register and output muxing live in kt8_datareg.

## Test plan
Bench ALU model: op 0 -> a+b, op 1 -> a-b, truncated to DW.
- Reset, LOAD r1=3, LOAD r2=5, ALU op0 rd=r3 rsa=r1 rsb=r2 -> a_o=3, b_o=5 in EXEC; done_o with result_o=8; MOVE r4<-r3 then gives result_o=8.
- ALU op1 r1-r1 into r5 with the zero flag compiled in -> result_o=0, zero_o=1; then LOAD r5=7 -> zero_o stays 1.
- LOAD r0=0xAA, then MOVE r6<-r0 -> the first done shows 0xAA, the second shows result_o=0.
- cmd_valid_i held high for 9 cycles -> exactly 3 handshakes; cmd_ready_o low in EXEC and DONE; a_o/b_o/op_o = 0 outside EXEC.
- ALU op0 with rd=rsa=r1 (r1=0xFF, r2=0x02) -> result_o=0x01 (wrap-around); r1 reads 0x01 afterwards.
- rst_ni pulsed low during EXEC of LOAD r7=0x55 -> no done pulse, r7=0, cmd_ready_o=1 immediately on reset assertion.
